// File: rtl/brianhg_gfx_i2s_pkg.sv
// Shared constants, frame type and clock-step helper for the GFX I2S audio transmitter.
// A frame is two 32-bit slots, left slot in the upper half.
package brianhg_gfx_i2s_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;

    typedef logic [FRAME_BITS-1:0] i2s_frame_t;

    // 64 BCLK periods per LRCK period means 128 BCLK toggles per sample
    function automatic logic [31:0] calc_step(input logic [31:0] sample_hz);
        return sample_hz << 7;
    endfunction

endpackage

// File: rtl/brianhg_gfx_frac_clk_div.sv
// Fractional clock divider: adds STEP each enabled cycle and toggles its output whenever the
// accumulator wraps past CLK_HZ, so the average toggle rate is exactly STEP toggles per second.
module brianhg_gfx_frac_clk_div #(
    parameter logic [31:0] CLK_HZ = 32'd54000000,
    parameter logic [31:0] STEP   = 32'd6144000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic en,
    output logic clk_out,
    output logic rise,
    output logic fall
);

    logic [31:0] acc_r;
    logic [31:0] nxt_s;
    logic [31:0] acc_nxt_s;
    logic        toggle_s;
    logic        clk_out_r;
    logic        run_s;

    // Next accumulator value and wrap detection; no overflow because acc < CLK_HZ < 2^31
    always_comb begin
        nxt_s = acc_r + STEP;
        if (nxt_s >= CLK_HZ) begin
            toggle_s  = 1'b1;
            acc_nxt_s = nxt_s - CLK_HZ;
        end else begin
            toggle_s  = 1'b0;
            acc_nxt_s = nxt_s;
        end
    end

    assign run_s   = en && !srst;
    assign rise    = run_s && toggle_s && !clk_out_r;
    assign fall    = run_s && toggle_s && clk_out_r;
    assign clk_out = clk_out_r;

    // Accumulator and divided clock, cleared synchronously while stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= 32'd0;
            clk_out_r <= 1'b0;
        end else if (srst) begin
            acc_r     <= 32'd0;
            clk_out_r <= 1'b0;
        end else if (en) begin
            acc_r <= acc_nxt_s;
            if (toggle_s) begin
                clk_out_r <= ~clk_out_r;
            end
        end
    end

endmodule

// File: rtl/brianhg_gfx_i2s_tx.sv
// Philips-format I2S transmitter: stereo samples arrive through a one-deep holding register
// and are shifted out MSB-first in 32-bit slots, one frame per LRCK period.
module brianhg_gfx_i2s_tx
    import brianhg_gfx_i2s_pkg::*;
#(
    parameter int CLK_HZ    = 54000000,
    parameter int SAMPLE_HZ = 48000,
    parameter int BITS      = 16
) (
    input  logic            CLK,
    input  logic            RESET_n,
    input  logic            ENABLE,
    input  logic [BITS-1:0] IN_L,
    input  logic [BITS-1:0] IN_R,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output logic            I2S_BCLK,
    output logic            I2S_LRCK,
    output logic            I2S_SDATA,
    output logic            UNDERFLOW,
    output logic [15:0]     UNDERFLOW_CNT
);

    localparam logic [31:0] STEP = calc_step(32'(SAMPLE_HZ));

    logic                 bclk_s;
    logic                 bclk_rise_unused_s;
    logic                 fall_s;
    logic                 hold_full_r;
    logic [BITS-1:0]      hold_l_r;
    logic [BITS-1:0]      hold_r_r;
    logic [5:0]           bit_cnt_r;
    logic [5:0]           p_s;
    logic                 load_s;
    logic                 accept_s;
    i2s_frame_t           frame_r;
    i2s_frame_t           new_frame_s;
    logic [SLOT_BITS-1:0] slot_l_s;
    logic [SLOT_BITS-1:0] slot_r_s;
    logic                 lrck_r;
    logic                 sdata_r;
    logic                 underflow_r;
    logic [15:0]          underflow_cnt_r;

    brianhg_gfx_frac_clk_div #(
        .CLK_HZ (32'(CLK_HZ)),
        .STEP   (STEP)
    ) u_bclk_div (
        .clk     (CLK),
        .rst_n   (RESET_n),
        .srst    (~ENABLE),
        .en      (ENABLE),
        .clk_out (bclk_s),
        .rise    (bclk_rise_unused_s),
        .fall    (fall_s)
    );

    // Slot position for this fall, load/accept decisions and the next frame image
    always_comb begin
        p_s         = bit_cnt_r + 6'd1;
        load_s      = fall_s && (p_s == 6'd63);
        accept_s    = IN_VALID && !hold_full_r;
        slot_l_s    = SLOT_BITS'(hold_l_r) << (SLOT_BITS - BITS);
        slot_r_s    = SLOT_BITS'(hold_r_r) << (SLOT_BITS - BITS);
        if (hold_full_r) begin
            new_frame_s = {slot_l_s, slot_r_s};
        end else begin
            new_frame_s = '0;
        end
    end

    assign IN_READY = ~hold_full_r;

    // Holding register: an accept on an underflow load refills it for the next frame
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            hold_full_r <= 1'b0;
            hold_l_r    <= '0;
            hold_r_r    <= '0;
        end else if (accept_s) begin
            hold_full_r <= 1'b1;
            hold_l_r    <= IN_L;
            hold_r_r    <= IN_R;
        end else if (load_s) begin
            hold_full_r <= 1'b0;
        end
    end

    // Serialiser: bit index ~p gives frame[63-p], and p=63 sends the old frame's last bit
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            bit_cnt_r <= 6'd62;
            frame_r   <= '0;
            lrck_r    <= 1'b0;
            sdata_r   <= 1'b0;
        end else if (!ENABLE) begin
            bit_cnt_r <= 6'd62;
            frame_r   <= '0;
            lrck_r    <= 1'b0;
            sdata_r   <= 1'b0;
        end else if (fall_s) begin
            bit_cnt_r <= p_s;
            sdata_r   <= frame_r[~p_s];
            lrck_r    <= (p_s >= 6'd31) && (p_s <= 6'd62);
            if (load_s) begin
                frame_r <= new_frame_s;
            end
        end
    end

    // Underflow pulse and saturating counter
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            underflow_r     <= 1'b0;
            underflow_cnt_r <= 16'd0;
        end else begin
            underflow_r <= load_s && !hold_full_r;
            if (load_s && !hold_full_r && (underflow_cnt_r != 16'hFFFF)) begin
                underflow_cnt_r <= underflow_cnt_r + 16'd1;
            end
        end
    end

    assign I2S_BCLK      = bclk_s;
    assign I2S_LRCK      = lrck_r;
    assign I2S_SDATA     = sdata_r;
    assign UNDERFLOW     = underflow_r;
    assign UNDERFLOW_CNT = underflow_cnt_r;

endmodule
